// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Logic, add/sub and set-less-than finish in one
// cycle; multiply (shift-add) and unsigned divide/remainder (restoring) run
// one bit per cycle for WIDTH cycles. The control FSM is IDLE -> BUSY/DONE -> IDLE.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             divz_o
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opa_q;   // multiplicand (MUL) / dividend-quotient shifter (DIV)
    logic [WIDTH-1:0] opb_q;   // multiplier (MUL) / divisor (DIV)
    logic [WIDTH-1:0] acc_q;   // partial product (MUL) / partial remainder (DIV)

    logic             accept;
    logic             is_iter;
    logic             last_iter;

    logic signed [WIDTH-1:0] sa, sb, sum_s, dif_s;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] step_a, step_b, step_acc, fin_res;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Signed overflow: operands differ in sign and the difference takes b's sign.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign is_iter   = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
    assign accept    = start_i && (state_q == S_IDLE) && !rst_i;
    assign last_iter = (state_q == S_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = is_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake is a pure decode of the registered state.
    always_comb begin
        ready_o = (state_q == S_IDLE);
        valid_o = (state_q == S_DONE);
    end

    // Single-cycle ALU on the live inputs, captured into result_o on accept.
    always_comb begin
        sa      = $signed(src1_i);
        sb      = $signed(src2_i);
        sum_s   = sa + sb;
        dif_s   = sa - sb;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  begin alu_res = sum_s; alu_ovf = add_ovf(sa, sb, sum_s); end
            OP_SUB:  begin alu_res = dif_s; alu_ovf = sub_ovf(sa, sb, dif_s); end
            OP_SLT:  alu_res = WIDTH'(sa < sb);
            OP_NOR:  alu_res = ~(src1_i | src2_i);
            default: alu_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        rem_sh = {acc_q, opa_q[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, opb_q});
        if (op_q == OP_MUL) begin
            step_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;
            step_a   = opa_q << 1;
            step_b   = opb_q >> 1;
        end else begin
            // When it fits, the true difference is below the divisor, so the
            // modulo-2^WIDTH subtraction is exact.
            step_acc = fits ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
            step_a   = {opa_q[WIDTH-2:0], fits};
            step_b   = opb_q;
        end
        fin_res = (op_q == OP_DIVU) ? step_a : step_acc;
    end

    // Iteration counter.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 cnt_q <= '0;
        else if (accept)           cnt_q <= '0;
        else if (state_q == S_BUSY) cnt_q <= cnt_q + 1'b1;
    end

    // Working operands: captured on accept, stepped while busy.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q  <= ctrl_i;
            opa_q <= src1_i;
            opb_q <= src2_i;
            acc_q <= '0;
        end else if (state_q == S_BUSY) begin
            opa_q <= step_a;
            opb_q <= step_b;
            acc_q <= step_acc;
        end
    end

    // Result and flags: written only when an operation completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            ovf_o    <= 1'b0;
            divz_o   <= 1'b0;
        end else if (accept && !is_iter) begin
            result_o <= alu_res;
            zero_o   <= (alu_res == '0);
            ovf_o    <= alu_ovf;
            divz_o   <= 1'b0;
        end else if (last_iter) begin
            result_o <= fin_res;
            zero_o   <= (fin_res == '0);
            ovf_o    <= 1'b0;
            divz_o   <= (op_q != OP_MUL) && (opb_q == '0);
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit and an 8-bit instance share the clock.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s32_start, s8_start;
    logic [31:0] s32_a, s32_b;
    logic [7:0]  s8_a, s8_b;
    logic [3:0]  s32_ctrl, s8_ctrl;
    logic        r32_ready, r32_valid, r32_zero, r32_ovf, r32_divz;
    logic        r8_ready, r8_valid, r8_zero, r8_ovf, r8_divz;
    logic [31:0] r32_res;
    logic [7:0]  r8_res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          o_lat, o_vcyc;
    logic [31:0] o_res;
    logic        o_z, o_o, o_d;
    bit          o_rdy_busy, o_stable;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(s32_start), .src1_i(s32_a), .src2_i(s32_b),
        .ctrl_i(s32_ctrl), .ready_o(r32_ready), .valid_o(r32_valid), .result_o(r32_res),
        .zero_o(r32_zero), .ovf_o(r32_ovf), .divz_o(r32_divz)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8_start), .src1_i(s8_a), .src2_i(s8_b),
        .ctrl_i(s8_ctrl), .ready_o(r8_ready), .valid_o(r8_valid), .result_o(r8_res),
        .zero_o(r8_zero), .ovf_o(r8_ovf), .divz_o(r8_divz)
    );

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic cur_ready(input bit w8);
        return w8 ? r8_ready : r32_ready;
    endfunction

    function automatic logic cur_valid(input bit w8);
        return w8 ? r8_valid : r32_valid;
    endfunction

    function automatic logic [31:0] cur_res(input bit w8);
        return w8 ? {24'd0, r8_res} : r32_res;
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            s8_start = st; s8_ctrl = c; s8_a = a[7:0]; s8_b = b[7:0];
        end else begin
            s32_start = st; s32_ctrl = c; s32_a = a; s32_b = b;
        end
    endtask

    // Issue one operation once the block is ready; record latency (cycles
    // after the accept cycle), outputs, and behaviour while waiting.
    task automatic exec(input bit w8, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit junk);
        logic [31:0] prev;
        for (int i = 0; i < 50 && !cur_ready(w8); i++) begin
            @(posedge clk); #1;
        end
        prev = cur_res(w8);
        drive(w8, 1'b1, c, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, 4'd1, ~a, ~b);
        o_lat = -1; o_rdy_busy = 0; o_stable = 1;
        for (int k = 1; k <= 100; k++) begin
            drive(w8, 1'b0, 4'd1, ~a, ~b);
            if (cur_valid(w8)) begin
                o_lat = k;
                break;
            end
            if (cur_ready(w8)) o_rdy_busy = 1;
            if (cur_res(w8) !== prev) o_stable = 0;
            if (junk) drive(w8, 1'b1, 4'd2, 32'd1, 32'd1);
            @(posedge clk); #1;
        end
        o_res = cur_res(w8);
        o_z = w8 ? r8_zero : r32_zero;
        o_o = w8 ? r8_ovf : r32_ovf;
        o_d = w8 ? r8_divz : r32_divz;
        o_vcyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 4'd2, 32'd1, 32'd2);
        drive(1, 1'b1, 4'd2, 32'd1, 32'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        checks++; if (r32_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", r32_ready); end
        checks++; if (r32_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", r32_valid); end
        checks++; if (r32_res !== 32'd0) begin errors++; $display("FAIL rst_result: got %h want 00000000", r32_res); end
        checks++; if ({r32_zero, r32_ovf, r32_divz} !== 3'b100) begin errors++; $display("FAIL rst_flags: got z%b o%b d%b want z1 o0 d0", r32_zero, r32_ovf, r32_divz); end
        checks++; if ({r8_ready, r8_valid, r8_res, r8_zero} !== {2'b10, 8'h00, 1'b1}) begin errors++; $display("FAIL rst_w8: got rdy%b vld%b res%h z%b want rdy1 vld0 res00 z1", r8_ready, r8_valid, r8_res, r8_zero); end
        @(posedge clk); #1;
        checks++; if ({r32_ready, r32_valid} !== 2'b10) begin errors++; $display("FAIL rst_start_ignored: got rdy%b vld%b want rdy1 vld0", r32_ready, r32_valid); end
    endtask

    task automatic test_add_sub();
        exec(0, 4'd2, 32'h7FFFFFFF, 32'h00000001, 0);
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", o_lat); end
        checks++; if (o_res !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h want 80000000", o_res); end
        checks++; if ({o_z, o_o, o_d} !== 3'b010) begin errors++; $display("FAIL add_flags: got z%b o%b d%b want z0 o1 d0", o_z, o_o, o_d); end
        exec(0, 4'd6, 32'd5, 32'd5, 0);
        checks++; if (o_res !== 32'd0 || {o_z, o_o} !== 2'b10) begin errors++; $display("FAIL sub_zero: got %h z%b o%b want 00000000 z1 o0", o_res, o_z, o_o); end
        exec(0, 4'd6, 32'h80000000, 32'd1, 0);
        checks++; if (o_res !== 32'h7FFFFFFF || {o_z, o_o} !== 2'b01) begin errors++; $display("FAIL sub_ovf: got %h z%b o%b want 7fffffff z0 o1", o_res, o_z, o_o); end
    endtask

    task automatic test_logic();
        exec(0, 4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
        checks++; if (o_res !== 32'h00F000F0) begin errors++; $display("FAIL and: got %h want 00f000f0", o_res); end
        exec(0, 4'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
        checks++; if (o_res !== 32'hFFF0FFF0) begin errors++; $display("FAIL or: got %h want fff0fff0", o_res); end
        exec(0, 4'd12, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
        checks++; if (o_res !== 32'h000F000F) begin errors++; $display("FAIL nor: got %h want 000f000f", o_res); end
        exec(0, 4'd7, 32'hFFFFFFFF, 32'd1, 0);
        checks++; if (o_res !== 32'd1 || o_z !== 1'b0) begin errors++; $display("FAIL slt_neg: got %h z%b want 00000001 z0", o_res, o_z); end
        exec(0, 4'd7, 32'd1, 32'hFFFFFFFF, 0);
        checks++; if (o_res !== 32'd0 || o_z !== 1'b1) begin errors++; $display("FAIL slt_pos: got %h z%b want 00000000 z1", o_res, o_z); end
        exec(0, 4'd3, 32'd5, 32'd9, 0);
        checks++; if (o_lat !== 1 || o_res !== 32'd0 || {o_z, o_o, o_d} !== 3'b100) begin errors++; $display("FAIL undef_op: got lat%0d %h z%b o%b d%b want lat1 00000000 z1 o0 d0", o_lat, o_res, o_z, o_o, o_d); end
    endtask

    task automatic test_mul();
        exec(0, 4'd11, 32'h00010000, 32'h00010001, 1);
        checks++; if (o_lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", o_lat); end
        checks++; if (o_res !== 32'h00010000 || {o_z, o_o, o_d} !== 3'b000) begin errors++; $display("FAIL mul_result: got %h z%b o%b d%b want 00010000 z0 o0 d0", o_res, o_z, o_o, o_d); end
        checks++; if (o_rdy_busy !== 0) begin errors++; $display("FAIL mul_ready_busy: got ready seen %0d want 0", o_rdy_busy); end
        checks++; if (o_stable !== 1) begin errors++; $display("FAIL mul_result_hold: got stable %0d want 1", o_stable); end
        exec(0, 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        checks++; if (o_res !== 32'd1) begin errors++; $display("FAIL mul_wrap: got %h want 00000001", o_res); end
    endtask

    task automatic test_div();
        exec(0, 4'd13, 32'd100, 32'd7, 0);
        checks++; if (o_lat !== 33 || o_res !== 32'd14 || o_d !== 1'b0) begin errors++; $display("FAIL divu: got lat%0d %h d%b want lat33 0000000e d0", o_lat, o_res, o_d); end
        exec(0, 4'd14, 32'd100, 32'd7, 0);
        checks++; if (o_res !== 32'd2 || o_d !== 1'b0) begin errors++; $display("FAIL remu: got %h d%b want 00000002 d0", o_res, o_d); end
        exec(0, 4'd13, 32'd9, 32'd0, 0);
        checks++; if (o_lat !== 33 || o_res !== 32'hFFFFFFFF || {o_z, o_o, o_d} !== 3'b001) begin errors++; $display("FAIL divu_zero: got lat%0d %h z%b o%b d%b want lat33 ffffffff z0 o0 d1", o_lat, o_res, o_z, o_o, o_d); end
        exec(0, 4'd14, 32'd9, 32'd0, 0);
        checks++; if (o_res !== 32'd9 || o_d !== 1'b1) begin errors++; $display("FAIL remu_zero: got %h d%b want 00000009 d1", o_res, o_d); end
    endtask

    task automatic test_valid_pulse();
        exec(0, 4'd2, 32'd1, 32'd1, 0);
        @(posedge clk); #1;
        checks++; if ({r32_valid, r32_ready} !== 2'b01 || r32_res !== 32'd2) begin errors++; $display("FAIL valid_pulse: got vld%b rdy%b %h want vld0 rdy1 00000002", r32_valid, r32_ready, r32_res); end
    endtask

    task automatic test_back_to_back();
        int v1;
        exec(0, 4'd2, 32'd10, 32'd20, 0);
        v1 = o_vcyc;
        checks++; if (o_res !== 32'd30) begin errors++; $display("FAIL b2b_first: got %h want 0000001e", o_res); end
        exec(0, 4'd6, 32'd3, 32'd5, 0);
        checks++; if (o_res !== 32'hFFFFFFFE || o_o !== 1'b0) begin errors++; $display("FAIL b2b_second: got %h o%b want fffffffe o0", o_res, o_o); end
        checks++; if (o_vcyc - v1 !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d want 2", o_vcyc - v1); end
    endtask

    task automatic test_abort();
        int spurious = 0;
        bit early = 0;
        for (int i = 0; i < 50 && !r32_ready; i++) begin
            @(posedge clk); #1;
        end
        drive(0, 1'b1, 4'd11, 32'd3, 32'd5);
        @(posedge clk); #1;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (r32_valid) early = 1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (early !== 0) begin errors++; $display("FAIL abort_early_valid: got %0d want 0", early); end
        checks++; if ({r32_ready, r32_valid, r32_zero, r32_ovf, r32_divz} !== 5'b10100 || r32_res !== 32'd0) begin errors++; $display("FAIL abort_reset_state: got rdy%b vld%b %h z%b o%b d%b want rdy1 vld0 00000000 z1 o0 d0", r32_ready, r32_valid, r32_res, r32_zero, r32_ovf, r32_divz); end
        exec(0, 4'd2, 32'd2, 32'd3, 0);
        checks++; if (o_lat !== 1 || o_res !== 32'd5) begin errors++; $display("FAIL abort_fresh_add: got lat%0d %h want lat1 00000005", o_lat, o_res); end
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            if (r32_valid) spurious++;
            @(posedge clk); #1;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", spurious); end
    endtask

    task automatic test_w8();
        exec(1, 4'd2, 32'h7F, 32'h01, 0);
        checks++; if (o_lat !== 1 || o_res !== 32'h80 || {o_z, o_o} !== 2'b01) begin errors++; $display("FAIL w8_add: got lat%0d %h z%b o%b want lat1 80 z0 o1", o_lat, o_res, o_z, o_o); end
        exec(1, 4'd15, 32'h12, 32'h34, 0);
        checks++; if (o_res !== 32'h00 || {o_z, o_o, o_d} !== 3'b100) begin errors++; $display("FAIL w8_undef: got %h z%b o%b d%b want 00 z1 o0 d0", o_res, o_z, o_o, o_d); end
        exec(1, 4'd11, 32'h0F, 32'h11, 0);
        checks++; if (o_lat !== 9 || o_res !== 32'hFF) begin errors++; $display("FAIL w8_mul_ff: got lat%0d %h want lat9 ff", o_lat, o_res); end
        exec(1, 4'd11, 32'h10, 32'h10, 1);
        checks++; if (o_lat !== 9 || o_res !== 32'h00 || o_z !== 1'b1) begin errors++; $display("FAIL w8_mul_wrap: got lat%0d %h z%b want lat9 00 z1", o_lat, o_res, o_z); end
        exec(1, 4'd13, 32'd200, 32'd9, 0);
        checks++; if (o_res !== 32'd22) begin errors++; $display("FAIL w8_divu: got %h want 16", o_res); end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
        test_reset();
        test_add_sub();
        test_logic();
        test_mul();
        test_div();
        test_valid_pulse();
        test_back_to_back();
        test_abort();
        test_w8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
